// File: rtl/vdc_htiming_gen.sv
// Horizontal timing generator: column/pixel counters with prescaled pixel steps, display windows, sync.
// All timing registers are shadowed at line end (and on reset); advances only on enable ticks.
module vdc_htiming_gen #(
    parameter int          CW        = 8,
    parameter int          PW        = 4,
    parameter int          NWIN      = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [CW-1:0]      reg_ht,
    input  logic [CW-1:0]      reg_hd,
    input  logic [CW-1:0]      reg_hvs,
    input  logic [CW-1:0]      reg_hss,
    input  logic [3:0]         reg_hw,
    input  logic [PW-1:0]      reg_cth,
    input  logic [1:0]         reg_scale,
    input  logic [NWIN*CW-1:0] reg_deb,
    input  logic [NWIN*CW-1:0] reg_dee,
    output logic               newCol,
    output logic               endCol,
    output logic               lineEnd,
    output logic [CW-1:0]      col,
    output logic [PW-1:0]      pixel,
    output logic [NWIN-1:0]    hdispen,
    output logic               hVisible,
    output logic               hsync
);

    logic [CW-1:0]      sh_ht, sh_hd, sh_hvs, sh_hss;
    logic [3:0]         sh_hw;
    logic [PW-1:0]      sh_cth;
    logic [1:0]         sh_scale;
    logic [NWIN*CW-1:0] sh_deb, sh_dee;

    logic [1:0]         ps;
    logic [1:0]         smax;
    logic               hviscol;
    logic [3:0]         hscnt;
    logic [15:0]        lfsr;

    logic               step;
    logic               col_adv;
    logic               last_col;
    logic [CW-1:0]      c_next;
    logic [NWIN-1:0]    win_next;
    logic               vis_next;
    logic [CW:0]        vis_lo, vis_hi, c_ext;
    logic [15:0]        lfsr_next;

    always_ff @(posedge clk) begin
        if (reset || (enable && lineEnd)) begin
            sh_ht    <= reg_ht;
            sh_hd    <= reg_hd;
            sh_hvs   <= reg_hvs;
            sh_hss   <= reg_hss;
            sh_hw    <= reg_hw;
            sh_cth   <= reg_cth;
            sh_scale <= reg_scale;
            sh_deb   <= reg_deb;
            sh_dee   <= reg_dee;
        end
    end

    always_comb begin
        case (sh_scale)
            2'd1:    smax = 2'd1;
            2'd2:    smax = 2'd3;
            default: smax = 2'd0;
        endcase
    end

    assign step     = (ps == smax);
    assign col_adv  = step && (pixel == sh_cth);
    assign last_col = (col == sh_ht);
    assign c_next   = last_col ? '0 : col + 1'b1;

    // Visibility range is compared one bit wider so hvs+hd never wraps back into range.
    assign c_ext    = {1'b0, c_next};
    assign vis_lo   = {1'b0, sh_hvs};
    assign vis_hi   = {1'b0, sh_hvs} + {1'b0, sh_hd};
    assign vis_next = (c_ext >= vis_lo) && (c_ext < vis_hi);

    always_comb begin
        win_next = hdispen;
        for (int i = 0; i < NWIN; i++) begin
            if (sh_deb[i*CW +: CW] != sh_dee[i*CW +: CW]) begin
                if (c_next == sh_deb[i*CW +: CW]) win_next[i] = 1'b1;
                if (c_next == sh_dee[i*CW +: CW]) win_next[i] = 1'b0;
            end else if (c_next == sh_deb[i*CW +: CW]) begin
                // Degenerate window: begin and end collide, so the LFSR breaks the tie.
                win_next[i] = lfsr[0];
            end
        end
    end

    // Galois form of x^16+x^14+x^13+x^11+1.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            ps      <= 2'd0;
            pixel   <= '0;
            col     <= '0;
            hdispen <= '0;
            hviscol <= 1'b0;
            hscnt   <= 4'd0;
            lfsr    <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= lfsr_next;
            ps   <= step ? 2'd0 : ps + 2'd1;
            if (step) pixel <= (pixel == sh_cth) ? '0 : pixel + 1'b1;
            if (col_adv) begin
                col     <= c_next;
                hdispen <= win_next;
                hviscol <= vis_next;
                if (c_next == sh_hss)
                    hscnt <= sh_hw;
                else if (hscnt != 4'd0)
                    hscnt <= hscnt - 4'd1;
            end
        end
    end

    assign endCol   = (pixel == sh_cth) && step;
    assign newCol   = (pixel == '0) && (ps == 2'd0);
    assign lineEnd  = endCol && last_col;
    assign hVisible = hviscol & hdispen[0];
    assign hsync    = |hscnt;

endmodule
